// File: rtl/fp4_fft_stream_ctrl.sv
// Streaming front/back end for the FP4 FFT core: loads one frame of samples,
// kicks the transform, waits for completion, then streams the bins back out.
module fp4_fft_stream_ctrl #(
    parameter int MAX_N          = 32,
    parameter int ADDR_WIDTH     = $clog2(MAX_N),
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [7:0]            s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [7:0]            m_data,
    output logic [ADDR_WIDTH-1:0] m_index,
    output logic                  m_last,
    output logic                  fft_wr_en,
    output logic [ADDR_WIDTH-1:0] fft_wr_addr,
    output logic [7:0]            fft_wr_data,
    output logic [ADDR_WIDTH-1:0] fft_rd_addr,
    input  logic [7:0]            fft_rd_data,
    output logic                  fft_start,
    input  logic                  fft_done,
    output logic                  busy,
    output logic                  err,
    output logic [7:0]            frame_cnt
);

    localparam logic [2:0] S_LOAD     = 3'd0;
    localparam logic [2:0] S_KICK     = 3'd1;
    localparam logic [2:0] S_WAIT     = 3'd2;
    localparam logic [2:0] S_RD_ISSUE = 3'd3;
    localparam logic [2:0] S_RD_WAIT  = 3'd4;
    localparam logic [2:0] S_OUT_HOLD = 3'd5;

    localparam int                    TW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_A = ADDR_WIDTH'(MAX_N - 1);
    localparam logic [TW-1:0]         LAST_T = TW'(TIMEOUT_CYCLES - 1);

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] load_cnt_q, load_cnt_d;
    logic [ADDR_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [7:0]            m_data_q, m_data_d;
    logic                  err_q, err_d;
    logic [7:0]            frame_q, frame_d;
    logic                  accept;

    // Gate with rst so nothing handshakes while the block is held in reset.
    assign s_ready = (state_q == S_LOAD) && rst;
    assign accept  = s_ready && s_valid;

    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        rd_cnt_d   = rd_cnt_q;
        timer_d    = timer_q;
        m_data_d   = m_data_q;
        err_d      = err_q;
        frame_d    = frame_q;
        case (state_q)
            S_LOAD: begin
                if (accept) begin
                    if (load_cnt_q == LAST_A) begin
                        load_cnt_d = '0;
                        state_d    = S_KICK;
                    end else begin
                        load_cnt_d = load_cnt_q + 1'b1;
                    end
                end
            end
            S_KICK: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                timer_d = timer_q + 1'b1;
                // Completion on the final cycle still counts as success.
                if (fft_done) begin
                    rd_cnt_d = '0;
                    state_d  = S_RD_ISSUE;
                end else if (timer_q == LAST_T) begin
                    err_d      = 1'b1;
                    load_cnt_d = '0;
                    state_d    = S_LOAD;
                end
            end
            S_RD_ISSUE: state_d = S_RD_WAIT;
            S_RD_WAIT: begin
                m_data_d = fft_rd_data;
                state_d  = S_OUT_HOLD;
            end
            S_OUT_HOLD: begin
                if (m_ready) begin
                    if (rd_cnt_q == LAST_A) begin
                        rd_cnt_d = '0;
                        frame_d  = frame_q + 8'd1;
                        state_d  = S_LOAD;
                    end else begin
                        rd_cnt_d = rd_cnt_q + 1'b1;
                        state_d  = S_RD_ISSUE;
                    end
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_LOAD;
            load_cnt_q <= '0;
            rd_cnt_q   <= '0;
            timer_q    <= '0;
            m_data_q   <= '0;
            err_q      <= 1'b0;
            frame_q    <= '0;
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            timer_q    <= timer_d;
            m_data_q   <= m_data_d;
            err_q      <= err_d;
            frame_q    <= frame_d;
        end
    end

    assign fft_wr_en   = accept;
    assign fft_wr_addr = load_cnt_q;
    assign fft_wr_data = accept ? s_data : 8'd0;
    assign fft_rd_addr = rd_cnt_q;
    assign fft_start   = (state_q == S_KICK);
    assign m_valid     = (state_q == S_OUT_HOLD);
    assign m_data      = m_data_q;
    assign m_index     = rd_cnt_q;
    assign m_last      = m_valid && (rd_cnt_q == LAST_A);
    assign busy        = (state_q != S_LOAD);
    assign err         = err_q;
    assign frame_cnt   = frame_q;

endmodule

// File: tb/tb_fp4_fft_stream_ctrl.sv
// Directed bench for fp4_fft_stream_ctrl: loads frames, models the FFT result
// memory as addr^0xA5 with one-cycle read latency, and checks the output stream.
module tb_fp4_fft_stream_ctrl;

    localparam int N  = 32;
    localparam int AW = 5;
    localparam int TO = 128;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid, s_ready;
    logic [7:0]    s_data;
    logic          m_valid, m_ready, m_last;
    logic [7:0]    m_data;
    logic [AW-1:0] m_index;
    logic          fft_wr_en;
    logic [AW-1:0] fft_wr_addr, fft_rd_addr;
    logic [7:0]    fft_wr_data, fft_rd_data;
    logic          fft_start, fft_done, busy, err;
    logic [7:0]    frame_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    fp4_fft_stream_ctrl #(.MAX_N(N), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_index(m_index), .m_last(m_last),
        .fft_wr_en(fft_wr_en), .fft_wr_addr(fft_wr_addr), .fft_wr_data(fft_wr_data),
        .fft_rd_addr(fft_rd_addr), .fft_rd_data(fft_rd_data),
        .fft_start(fft_start), .fft_done(fft_done),
        .busy(busy), .err(err), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) fft_rd_data <= {3'b000, fft_rd_addr} ^ 8'hA5;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge in LOAD; returns at a negedge.
    task automatic load_frame(input logic [7:0] base, input bit gaps, input int count);
        for (int i = 0; i < count; i++) begin
            if (gaps && (i % 4 == 1)) begin
                s_valid  = 1'b0;
                fft_done = 1'b1;
                #1;
                chk("gap_wr_en", fft_wr_en, 0);
                chk("gap_s_ready", s_ready, 1);
                chk("gap_start", fft_start, 0);
                @(negedge clk);
                fft_done = 1'b0;
            end
            s_valid = 1'b1;
            s_data  = 8'(base + i);
            #1;
            chk("ld_wr_en", fft_wr_en, 1);
            chk("ld_wr_addr", fft_wr_addr, i);
            chk("ld_wr_data", fft_wr_data, 8'(base + i));
            chk("ld_busy", busy, 0);
            @(negedge clk);
        end
        s_valid = 1'b0;
    endtask

    // At the KICK negedge; returns at the first WAIT_DONE negedge.
    task automatic kick_check();
        #1;
        chk("kick_start", fft_start, 1);
        chk("kick_s_ready", s_ready, 0);
        chk("kick_busy", busy, 1);
        s_valid = 1'b1;
        s_data  = 8'hEE;
        #1;
        chk("kick_no_wr", fft_wr_en, 0);
        @(negedge clk);
        s_valid = 1'b0;
        #1;
        chk("start_single", fft_start, 0);
        chk("wait_s_ready", s_ready, 0);
    endtask

    task automatic wait_done(input int d);
        repeat (d - 1) @(negedge clk);
        fft_done = 1'b1;
        @(negedge clk);
        fft_done = 1'b0;
    endtask

    // Entered at the RD_ISSUE negedge; returns at the LOAD negedge after the last bin.
    task automatic read_frame(input bit rnd);
        int k;
        int guard;
        k = 0;
        guard = 0;
        m_ready = 1'b1;
        #1;
        chk("rdi_m_valid", m_valid, 0);
        chk("rdi_rd_addr", fft_rd_addr, 0);
        chk("rdi_busy", busy, 1);
        @(negedge clk);
        #1;
        chk("rdw_m_valid", m_valid, 0);
        @(negedge clk);
        while (k < N && guard < 600) begin
            #1;
            if (m_valid) begin
                chk("out_data", m_data, 8'(k) ^ 8'hA5);
                chk("out_index", m_index, k);
                chk("out_last", m_last, (k == N - 1));
            end
            m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (m_valid && m_ready) k++;
            @(negedge clk);
            guard++;
        end
        chk("xfer_count", k, N);
        m_ready = 1'b0;
        #1;
        chk("post_m_valid", m_valid, 0);
        chk("post_busy", busy, 0);
        chk("post_s_ready", s_ready, 1);
    endtask

    initial begin
        rst      = 1'b0;
        s_valid  = 1'b1;
        s_data   = 8'h55;
        m_ready  = 1'b0;
        fft_done = 1'b0;
        #12;
        chk("rst_s_ready", s_ready, 0);
        chk("rst_wr_en", fft_wr_en, 0);
        chk("rst_wr_data", fft_wr_data, 0);
        chk("rst_wr_addr", fft_wr_addr, 0);
        chk("rst_rd_addr", fft_rd_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_index", m_index, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_start", fft_start, 0);
        chk("rst_err", err, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        @(negedge clk);
        s_valid = 1'b0;
        rst     = 1'b1;
        #1;
        chk("rel_s_ready", s_ready, 1);
        @(negedge clk);

        // Frame 1: samples 0x00..0x1F, done 100 cycles after start, m_ready held.
        load_frame(8'h00, 1'b0, N);
        kick_check();
        wait_done(100);
        read_frame(1'b0);
        chk("f1_frame_cnt", frame_cnt, 1);
        chk("f1_err", err, 0);

        // Frame 2: gapped input with stray fft_done, done on the last allowed cycle.
        load_frame(8'h40, 1'b1, N);
        kick_check();
        wait_done(TO);
        #1;
        chk("to_edge_err", err, 0);
        chk("to_edge_busy", busy, 1);
        read_frame(1'b1);
        chk("f2_frame_cnt", frame_cnt, 2);

        // Frame 3: fft_done never arrives -> timeout.
        load_frame(8'h80, 1'b0, N);
        kick_check();
        repeat (TO - 1) @(negedge clk);
        #1;
        chk("to_pre_err", err, 0);
        chk("to_pre_busy", busy, 1);
        @(negedge clk);
        #1;
        chk("to_err", err, 1);
        chk("to_busy", busy, 0);
        chk("to_s_ready", s_ready, 1);
        chk("to_frame_cnt", frame_cnt, 2);
        @(negedge clk);

        // Frame 4: normal operation after the error, err stays set.
        load_frame(8'hC0, 1'b0, N);
        kick_check();
        wait_done(100);
        read_frame(1'b1);
        chk("f4_frame_cnt", frame_cnt, 3);
        chk("f4_err_sticky", err, 1);

        // Reset after 10 accepted samples.
        @(negedge clk);
        load_frame(8'h10, 1'b0, 10);
        rst = 1'b0;
        #1;
        chk("mid_s_ready", s_ready, 0);
        chk("mid_busy", busy, 0);
        chk("mid_err", err, 0);
        chk("mid_frame_cnt", frame_cnt, 0);
        chk("mid_m_data", m_data, 0);
        chk("mid_wr_addr", fft_wr_addr, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        load_frame(8'h20, 1'b0, N);
        kick_check();
        wait_done(100);
        read_frame(1'b0);
        chk("f5_frame_cnt", frame_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
